// File: rtl/dram_ref_arb_pkg.sv
// Shared types and default timing for the DRAM refresh/CPU arbiter.
package dram_ref_arb_pkg;

    localparam int DEF_REF_INTERVAL = 375;
    localparam int DEF_REF_MAXPEND  = 4;
    localparam int DEF_URG_LEVEL    = 2;
    localparam int DEF_TRP          = 2;
    localparam int DEF_TRAS_REF     = 3;

    localparam int PEND_W = 3;
    localparam int CNT_W  = 3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RAS  = 3'd1,
        CAS  = 3'd2,
        HOLD = 3'd3,
        PRE  = 3'd4,
        RCAS = 3'd5,
        RRAS = 3'd6,
        RPRE = 3'd7
    } arbState_e;

endpackage

// File: rtl/dram_ref_arb_ref_timer.sv
// Refresh interval timer and saturating pending-refresh backlog.
module ref_timer
    import dram_ref_arb_pkg::*;
#(
    parameter int REF_INTERVAL = DEF_REF_INTERVAL,
    parameter int REF_MAXPEND  = DEF_REF_MAXPEND,
    parameter int URG_LEVEL    = DEF_URG_LEVEL
) (
    input  logic              gclk,
    input  logic              grst_n,
    input  logic              refDec,
    output logic [PEND_W-1:0] refPend,
    output logic              refUrg,
    output logic              refLost
);

    localparam int INT_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

    logic [INT_W-1:0] intervalCnt;
    logic             tick;

    assign tick = (intervalCnt == '0);

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            intervalCnt <= INT_W'(REF_INTERVAL - 1);
            refPend     <= '0;
        end else begin
            intervalCnt <= tick ? INT_W'(REF_INTERVAL - 1) : intervalCnt - 1'b1;
            // A tick and a completed refresh in the same cycle cancel out
            if (tick && !refDec && refPend != PEND_W'(REF_MAXPEND))
                refPend <= refPend + 1'b1;
            else if (refDec && !tick && refPend != '0)
                refPend <= refPend - 1'b1;
        end
    end

    assign refUrg  = (refPend >= PEND_W'(URG_LEVEL));
    assign refLost = tick && !refDec && (refPend == PEND_W'(REF_MAXPEND));

endmodule

// File: rtl/dram_ref_arb.sv
// DRAM sequencer arbitrating FSB RAM cycles against CAS-before-RAS refresh.
// REF_IDLE_DRAIN_EN: back-to-back refresh from RPRE while no CPU request waits.
module dram_ref_arb
    import dram_ref_arb_pkg::*;
#(
    parameter int REF_INTERVAL = DEF_REF_INTERVAL,
    parameter int REF_MAXPEND  = DEF_REF_MAXPEND,
    parameter int URG_LEVEL    = DEF_URG_LEVEL,
    parameter int TRP          = DEF_TRP,
    parameter int TRAS_REF     = DEF_TRAS_REF
) (
    input  logic              FCLK,
    input  logic              nRES,
    input  logic              BACT,
    input  logic              RAMCS,
    input  logic              nWE,
    input  logic              nUDS,
    input  logic              nLDS,
    output logic              nRAS,
    output logic              nCAS,
    output logic              RASEL,
    output logic              nRAMUWE,
    output logic              nRAMLWE,
    output logic              nOE,
    output logic              RAMReady,
    output logic              RefUrg,
    output logic [PEND_W-1:0] RefPend,
    output logic              RefLost
);

    arbState_e        state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic             refDec;
    logic             cpuReq;

    assign cpuReq = BACT & RAMCS;

    ref_timer #(
        .REF_INTERVAL(REF_INTERVAL),
        .REF_MAXPEND (REF_MAXPEND),
        .URG_LEVEL   (URG_LEVEL)
    ) uTimer (
        .gclk   (FCLK),
        .grst_n (nRES),
        .refDec (refDec),
        .refPend(RefPend),
        .refUrg (RefUrg),
        .refLost(RefLost)
    );

    always_ff @(posedge FCLK or negedge nRES) begin
        if (!nRES) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        refDec    = 1'b0;
        case (state)
            IDLE: begin
                if (RefUrg && RefPend != '0) stateNext = RCAS;
                else if (cpuReq)             stateNext = RAS;
                else if (RefPend != '0)      stateNext = RCAS;
            end
            RAS, CAS, HOLD: begin
                if (BACT) begin
                    stateNext = (state == RAS) ? CAS : HOLD;
                end else begin
                    stateNext = PRE;
                    cntNext   = CNT_W'(TRP - 1);
                end
            end
            PRE: begin
                if (cnt != '0) cntNext = cnt - 1'b1;
                else           stateNext = IDLE;
            end
            RCAS: begin
                // Backlog is retired as RAS falls for the refresh
                stateNext = RRAS;
                cntNext   = CNT_W'(TRAS_REF - 1);
                refDec    = 1'b1;
            end
            RRAS: begin
                if (cnt != '0) begin
                    cntNext = cnt - 1'b1;
                end else begin
                    stateNext = RPRE;
                    cntNext   = CNT_W'(TRP - 1);
                end
            end
            RPRE: begin
                if (cnt != '0) cntNext = cnt - 1'b1;
`ifdef REF_IDLE_DRAIN_EN
                else if (RefPend != '0 && !cpuReq) stateNext = RCAS;
`endif
                else stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        nRAS     = 1'b1;
        nCAS     = 1'b1;
        RASEL    = 1'b1;
        nRAMUWE  = 1'b1;
        nRAMLWE  = 1'b1;
        nOE      = 1'b1;
        RAMReady = 1'b0;
        case (state)
            RAS: nRAS = 1'b0;
            CAS, HOLD: begin
                nRAS     = 1'b0;
                nCAS     = 1'b0;
                RASEL    = 1'b0;
                RAMReady = 1'b1;
                nOE      = ~nWE;
                nRAMUWE  = nWE | nUDS;
                nRAMLWE  = nWE | nLDS;
            end
            RCAS: nCAS = 1'b0;
            RRAS: begin
                nRAS = 1'b0;
                nCAS = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/dram_ref_arb.md
Name: dram_ref_arb

Overview:
- Sequences the motherboard DRAM between front-side-bus CPU RAM cycles and CAS-before-RAS refresh.
- Owns the refresh interval timer and a pending-refresh backlog.
- Produces nRAS, nCAS, the row/column address-mux select, byte write enables, nOE and RAMReady.
- Sits between chip-select decode (RAMCS, BACT) and the DRAM pins; RAMReady feeds FSB DTACK generation.

Parameters:
- REF_INTERVAL, 375: FCLK cycles between refresh ticks (15 us at 25 MHz).
- REF_MAXPEND, 4: saturation limit of the pending-refresh backlog.
- URG_LEVEL, 2: backlog count at or above which refresh preempts the CPU.
- TRP, 2: precharge cycles after any cycle (nRAS high).
- TRAS_REF, 3: cycles nRAS is held low during refresh.

Ports:
- FCLK  in  1  FSB clock; all state on rising edge.
- nRES  in  1  asynchronous active-low reset.
- BACT  in  1  FSB /AS cycle active.
- RAMCS  in  1  current cycle addresses DRAM.
- nWE  in  1  FSB write strobe, low = write.
- nUDS, nLDS  in  1 each  FSB byte strobes.
- nRAS, nCAS  out  1 each  DRAM strobes.
- RASEL  out  1  1 = row address on RA, 0 = column.
- nRAMUWE, nRAMLWE  out  1 each  byte write enables.
- nOE  out  1  DRAM read output enable.
- RAMReady  out  1  CPU cycle data valid / write accepted.
- RefUrg  out  1  backlog >= URG_LEVEL.
- RefPend  out  3  current backlog count.
- RefLost  out  1  one-cycle pulse when a tick arrives with backlog already at REF_MAXPEND.

Behaviour:
- Reset (async, nRES low):
  - Active-low outputs high: nRAS, nCAS, nRAMUWE, nRAMLWE, nOE.
  - RASEL=1; RAMReady=0, RefUrg=0, RefLost=0, RefPend=0.
  - State=IDLE; interval counter reloads REF_INTERVAL-1.
  - Reset mid-cycle drops all strobes immediately. No precharge is owed after reset release.
- Interval timer:
  - Decrements every FCLK; at 0 it reloads and issues a tick.
  - Tick increments RefPend, saturating at REF_MAXPEND; a tick at saturation pulses RefLost.
  - Tick and decrement in the same cycle: RefPend unchanged.
- States: IDLE, RAS, CAS, HOLD, PRE, RCAS, RRAS, RPRE.
- IDLE arbitration, evaluated each cycle:
  1. RefUrg and RefPend>0 -> RCAS. Urgent refresh beats a simultaneous CPU request.
  2. Else BACT and RAMCS -> RAS.
  3. Else RefPend>0 -> RCAS.
  4. Else stay in IDLE.
- CPU cycle:
  - RAS: nRAS low, RASEL=1. If BACT drops here, go to PRE with no RAMReady (aborted cycle).
  - CAS:
    - RASEL=0, nCAS low, RAMReady=1.
    - Read: nOE low.
    - Write: nRAMUWE = nUDS, nRAMLWE = nLDS.
  - HOLD:
    - Strobes and RAMReady keep their CAS values while BACT=1.
    - When BACT=0, go to PRE and deassert all strobes and RAMReady.
  - Latency: RAMReady is high 2 FCLK after the IDLE cycle that grants.
- PRE: nRAS high for TRP cycles, then IDLE.
- Refresh cycle:
  - RCAS: nCAS low for 1 cycle, nRAS high.
  - RRAS: nRAS low for TRAS_REF cycles, nCAS stays low. RefPend decrements on entry.
  - RPRE: all strobes high for TRP cycles, then IDLE.
  - Write enables stay high and nOE stays high throughout refresh.
- A CPU request arriving during refresh waits with RAMReady=0 and is served from IDLE afterwards.
- RefUrg is combinational from RefPend. RefPend width is 3 bits (REF_MAXPEND <= 7).

Optional Feature:
- Macro: REF_IDLE_DRAIN_EN.
- Defined: RPRE exits directly to RCAS when RefPend>0 and no CPU request is pending, draining the backlog back-to-back.
- Undefined: RPRE always returns to IDLE and arbitration runs normally, so the CPU may cut in after every refresh.

Decomposition:
- Shared package:
  - State enumeration (3-bit encoding).
  - Default constants REF_INTERVAL, REF_MAXPEND, URG_LEVEL, TRP, TRAS_REF.
  - RefPend width constant.
- One sub-module, ref_timer: interval down-counter, saturating backlog counter, RefUrg and RefLost generation.
- ref_timer takes a decrement strobe from the arbiter FSM.

Test Plan:
- CPU read, no refresh pending: BACT=RAMCS=1, nWE=1 at cycle 0.
  - nRAS low at cycle 1, nCAS low and nOE low and RAMReady=1 at cycle 2.
  - BACT dropped at cycle 5: strobes high at cycle 6, IDLE after 2 PRE cycles.
- CPU write, upper byte only: nWE=0, nUDS=0, nLDS=1 -> nRAMUWE=0 and nRAMLWE=1 in CAS/HOLD, nOE stays high.
- Refresh tick, bus idle: after 375 cycles RefPend=1 -> nCAS low 1 cycle, then nRAS low 3 cycles, then RefPend=0.
- Urgent vs CPU:
  - Hold a CPU cycle until RefPend=2, then issue a new request in the same cycle urgency is seen in IDLE.
  - Refresh runs first, RAMReady delayed until RPRE completes plus 2 cycles.
- Saturation: block the bus across 5 intervals -> RefPend sticks at 4, RefLost pulses exactly once, RefUrg=1.
- Reset during HOLD: nRES low -> all strobes high and RAMReady=0 asynchronously, RefPend=0; after release, IDLE with timer restarted at 374.
